// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//   Direct-mapped, write-back / write-allocate data cache controller sitting
//   between the MEM pipeline stage and a line-wide main memory.
//
// Ports
//   clk_i, rst_i       : clock (rising edge) and asynchronous active-low reset
//   cpu_addr_i         : byte address from the MEM stage
//   cpu_data_i         : store data
//   cpu_MemRead_i      : load request
//   cpu_MemWrite_i     : store request (wins when both are high)
//   cpu_data_o         : load data, 0 unless a load hit is presented
//   cpu_stall_o        : freezes PC and pipeline registers while high
//   mem_addr_o         : line-aligned memory address
//   mem_data_o         : write-back line data
//   mem_enable_o       : memory request valid
//   mem_write_o        : 1 = line write, 0 = line read
//   mem_data_i         : refill line data
//   mem_ack_i          : one-cycle completion pulse from memory
//   fsm_state_o        : current controller state, for debug/observation
//
// Memory handshake: mem_enable_o is a request held high with mem_addr_o,
// mem_write_o and mem_data_o stable until the cycle in which memory returns
// mem_ack_i; the transfer completes on that rising edge. mem_ack_i outside a
// WRITEBACK or ALLOCATE cycle carries no meaning and is ignored.
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_SETS = 16,
    parameter int LINE_W   = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        fsm_state_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t              state;
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    // Miss address is latched so the memory request stays stable even if the
    // CPU side changes or drops its request during the refill.
    logic [TAG_W-1:0]    miss_tag;
    logic [IDX_W-1:0]    miss_idx;

    logic [IDX_W-1:0]    cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [WSEL_W-1:0]   cpu_wsel;
    logic                req;
    logic                hit;
    logic                in_idle;
    logic                load_hit;
    logic                store_hit;
    logic                miss;
    logic                unused_addr_bits;

    assign cpu_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_tag  = cpu_addr_i[31 -: TAG_W];
    assign cpu_wsel = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit       = req & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign in_idle   = (state == IDLE);
    assign load_hit  = in_idle & hit & ~cpu_MemWrite_i;
    assign store_hit = in_idle & hit & cpu_MemWrite_i;
    assign miss      = in_idle & req & ~hit;

    assign cpu_data_o  = load_hit ? data_q[cpu_idx][32*int'(cpu_wsel) +: 32] : 32'd0;
    // Gated by reset so the pipeline is never frozen while reset is held.
    assign cpu_stall_o = rst_i & (~in_idle | miss);
    // The victim line cannot change while a miss is outstanding.
    assign mem_data_o  = data_q[miss_idx];
    assign fsm_state_o = state;

    // Control FSM with registered memory-side outputs and valid/dirty bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            miss_tag     <= '0;
            miss_idx     <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) begin
                        dirty_q[cpu_idx] <= 1'b1;
                    end
                    if (miss) begin
                        miss_tag     <= cpu_tag;
                        miss_idx     <= cpu_idx;
                        mem_enable_o <= 1'b1;
                        if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_q[cpu_idx], cpu_idx, {OFF_W{1'b0}}};
                        end else begin
                            state       <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state             <= UPDATE;
                        mem_enable_o      <= 1'b0;
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage; unreset, qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i) begin
            data_q[miss_idx] <= mem_data_i;
            tag_q[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            data_q[cpu_idx][32*int'(cpu_wsel) +: 32] <= cpu_data_i;
        end
    end

endmodule
